// File: rtl/lector_adc_pkg.sv
// Shared definitions for the MCP3201-style ADC reader: default widths and
// the frame sequencer state encoding.
package lector_adc_pkg;

    localparam int DATOS_BITS_DEF = 12;
    localparam int TOTAL_BITS_DEF = 15;
    localparam int CLK_DIV_DEF    = 4;
    localparam int T_CSH_DEF      = 8;

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        BAJO   = 3'd1,
        ALTO   = 3'd2,
        FIN    = 3'd3,
        ESPERA = 3'd4
    } estado_t;

endpackage

// File: rtl/lector_adc_divisor_sclk.sv
// Half-period timer for clk_adc: a CLK_DIV down-counter that emits a
// one-cycle tick every CLK_DIV enabled cycles.
module divisor_sclk #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] RECARGA = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == '0);

    // Clearing preloads the full half-period so the first tick lands
    // exactly CLK_DIV cycles after the enable rises.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RECARGA;
        end else if (en_i) begin
            cnt_d = tick_o ? RECARGA : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lector_adc.sv
// Serial master for an MCP3201-style ADC: frames cs, generates clk_adc,
// shifts the stream in on rising edges and publishes the 12-bit result.
module lector_adc
    import lector_adc_pkg::*;
#(
    parameter int DATOS_BITS = DATOS_BITS_DEF,
    parameter int TOTAL_BITS = TOTAL_BITS_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int T_CSH      = T_CSH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  datos_adc,
    output logic                  cs,
    output logic                  clk_adc,
    output logic [DATOS_BITS-1:0] dato,
    output logic                  dato_valido,
    output logic                  error_nulo,
    output logic                  ocupado
);

    localparam int CW = $clog2(TOTAL_BITS + 1);
    localparam int WW = (T_CSH > 1) ? $clog2(T_CSH) : 1;
    localparam logic [CW-1:0] ULTIMO     = CW'(TOTAL_BITS);
    localparam logic [WW-1:0] ESPERA_INI = WW'(T_CSH - 1);

    estado_t               estado_q;
    logic [DATOS_BITS:0]   shift_q;
    logic [DATOS_BITS:0]   shift_d;
    logic [CW-1:0]         bits_q;
    logic [WW-1:0]         espera_q;
    logic                  cs_q;
    logic                  clk_adc_q;
    logic [DATOS_BITS-1:0] dato_q;
    logic                  dato_valido_q;
    logic                  error_nulo_q;
    logic                  ocupado_q;
    logic                  corre;
    logic                  tick;

    assign corre = (estado_q == BAJO) || (estado_q == ALTO);

    divisor_sclk #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor (
        .clk_i   (clk),
        .clear_i (!rst_n || !corre),
        .en_i    (corre),
        .tick_o  (tick)
    );

    // Only the null bit and the data bits need keeping; the two leading
    // sample-clock bits simply fall off the top of the register.
    assign shift_d = {shift_q[DATOS_BITS-1:0], datos_adc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q      <= REPOSO;
            shift_q       <= '0;
            bits_q        <= '0;
            espera_q      <= '0;
            cs_q          <= 1'b1;
            clk_adc_q     <= 1'b0;
            dato_q        <= '0;
            dato_valido_q <= 1'b0;
            error_nulo_q  <= 1'b0;
            ocupado_q     <= 1'b0;
        end else begin
            dato_valido_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (start) begin
                        estado_q  <= BAJO;
                        cs_q      <= 1'b0;
                        ocupado_q <= 1'b1;
                        bits_q    <= '0;
                    end
                end
                BAJO: begin
                    if (tick) begin
                        estado_q  <= ALTO;
                        clk_adc_q <= 1'b1;
                        shift_q   <= shift_d;
                        bits_q    <= bits_q + CW'(1);
                    end
                end
                ALTO: begin
                    if (tick) begin
                        clk_adc_q <= 1'b0;
                        if (bits_q < ULTIMO) begin
                            estado_q <= BAJO;
                        end else begin
                            estado_q      <= FIN;
                            cs_q          <= 1'b1;
                            dato_q        <= shift_q[DATOS_BITS-1:0];
                            error_nulo_q  <= shift_q[DATOS_BITS];
                            dato_valido_q <= 1'b1;
                            espera_q      <= ESPERA_INI;
                        end
                    end
                end
                // The FIN cycle is the first of the T_CSH recovery cycles.
                FIN, ESPERA: begin
                    if (espera_q == '0) begin
                        estado_q  <= REPOSO;
                        ocupado_q <= 1'b0;
                    end else begin
                        estado_q <= ESPERA;
                        espera_q <= espera_q - WW'(1);
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign cs          = cs_q;
    assign clk_adc     = clk_adc_q;
    assign dato        = dato_q;
    assign dato_valido = dato_valido_q;
    assign error_nulo  = error_nulo_q;
    assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_lector_adc.sv
// Scoreboard bench for lector_adc: a default instance (CLK_DIV=4, T_CSH=8)
// and a fast-corner instance (CLK_DIV=1, T_CSH=1), each fed by an ADC model.
module tb_lector_adc;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic        datos0, datos1;
    logic        cs0, cs1;
    logic        clk_adc0, clk_adc1;
    logic [11:0] dato0, dato1;
    logic        valido0, valido1;
    logic        err0, err1;
    logic        ocup0, ocup1;

    int total = 0;
    int bad   = 0;

    logic [14:0] frames0[$];
    logic [14:0] frames1[$];
    logic [12:0] exp0[$];
    logic [12:0] exp1[$];
    logic [14:0] cur0, cur1;
    int idx0, idx1;
    int edges0 = 0, edges1 = 0;
    int nval0 = 0, nval1 = 0;

    lector_adc u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .datos_adc(datos0),
        .cs(cs0), .clk_adc(clk_adc0), .dato(dato0), .dato_valido(valido0),
        .error_nulo(err0), .ocupado(ocup0)
    );

    lector_adc #(.CLK_DIV(1), .T_CSH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .datos_adc(datos1),
        .cs(cs1), .clk_adc(clk_adc1), .dato(dato1), .dato_valido(valido1),
        .error_nulo(err1), .ocupado(ocup1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC models: a new frame is loaded when cs falls and each bit is
    // presented MSB-first, advancing on the clk_adc falling edge.
    initial begin datos0 = 1'b0; datos1 = 1'b0; cur0 = '0; cur1 = '0; idx0 = 0; idx1 = 0; end
    always @(negedge cs0) begin
        cur0 = (frames0.size() > 0) ? frames0.pop_front() : 15'h0;
        idx0 = 0;
        datos0 = cur0[14];
    end
    always @(negedge clk_adc0) begin
        if (!cs0 && idx0 < 14) begin idx0++; datos0 = cur0[14-idx0]; end
    end
    always @(negedge cs1) begin
        cur1 = (frames1.size() > 0) ? frames1.pop_front() : 15'h0;
        idx1 = 0;
        datos1 = cur1[14];
    end
    always @(negedge clk_adc1) begin
        if (!cs1 && idx1 < 14) begin idx1++; datos1 = cur1[14-idx1]; end
    end

    always @(posedge clk_adc0) edges0++;
    always @(posedge clk_adc1) edges1++;
    always @(negedge clk) begin
        if (valido0) nval0++;
        if (valido1) nval1++;
    end

    task automatic wait_valido0(output int j, output bit ok);
        ok = 1'b0; j = 0;
        while (!ok && j < 400) begin @(negedge clk); j++; if (valido0) ok = 1'b1; end
    endtask

    task automatic wait_valido1(output int j, output bit ok);
        ok = 1'b0; j = 0;
        while (!ok && j < 400) begin @(negedge clk); j++; if (valido1) ok = 1'b1; end
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (ocup0 && n < 400) begin @(negedge clk); n++; end
        total++;
        if (ocup0) begin bad++; $display("FAIL idle0 ocupado=%0b required 0 after timeout", ocup0); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        total += 6;
        if (cs0 !== 1'b1)      begin bad++; $display("FAIL rst_cs got=%b exp=1", cs0); end
        if (clk_adc0 !== 1'b0) begin bad++; $display("FAIL rst_clk_adc got=%b exp=0", clk_adc0); end
        if (dato0 !== 12'h000) begin bad++; $display("FAIL rst_dato got=%h exp=000", dato0); end
        if (valido0 !== 1'b0)  begin bad++; $display("FAIL rst_valido got=%b exp=0", valido0); end
        if (err0 !== 1'b0)     begin bad++; $display("FAIL rst_err got=%b exp=0", err0); end
        if (ocup0 !== 1'b0)    begin bad++; $display("FAIL rst_ocupado got=%b exp=0", ocup0); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete frame on the default instance, checked for exact timing.
    task automatic test_frame0(input logic [11:0] v, input logic nul, input string nm);
        int j, base;
        bit ok;
        logic [12:0] e;
        frames0.push_back({2'b11, nul, v});
        exp0.push_back({nul, v});
        start0 = 1'b1; base = edges0;
        @(negedge clk);
        start0 = 1'b0;
        total += 2;
        if (cs0 !== 1'b0)   begin bad++; $display("FAIL %s_cs_low got=%b exp=0", nm, cs0); end
        if (ocup0 !== 1'b1) begin bad++; $display("FAIL %s_ocupado got=%b exp=1", nm, ocup0); end
        wait_valido0(j, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL %s_timeout no dato_valido within %0d cycles", nm, j);
        end else begin
            e = exp0.pop_front();
            total += 6;
            if (j !== 120)            begin bad++; $display("FAIL %s_latency got=%0d exp=120", nm, j); end
            if (dato0 !== e[11:0])    begin bad++; $display("FAIL %s_dato got=%h exp=%h", nm, dato0, e[11:0]); end
            if (err0 !== e[12])       begin bad++; $display("FAIL %s_err got=%b exp=%b", nm, err0, e[12]); end
            if (cs0 !== 1'b1)         begin bad++; $display("FAIL %s_cs_fin got=%b exp=1", nm, cs0); end
            if (clk_adc0 !== 1'b0)    begin bad++; $display("FAIL %s_clk_fin got=%b exp=0", nm, clk_adc0); end
            if (edges0 - base !== 15) begin bad++; $display("FAIL %s_edges got=%0d exp=15", nm, edges0 - base); end
            @(negedge clk);
            total += 2;
            if (valido0 !== 1'b0)  begin bad++; $display("FAIL %s_pulse got=%b exp=0", nm, valido0); end
            if (dato0 !== e[11:0]) begin bad++; $display("FAIL %s_hold got=%h exp=%h", nm, dato0, e[11:0]); end
        end
        wait_idle0();
    endtask

    task automatic test_back_to_back();
        int j, cshi, olow;
        bit ok;
        logic [12:0] e;
        frames0.push_back({2'b11, 1'b0, 12'hFFF}); exp0.push_back({1'b0, 12'hFFF});
        frames0.push_back({2'b11, 1'b0, 12'h001}); exp0.push_back({1'b0, 12'h001});
        start0 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_valido0(j, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL b2b_timeout frame %0d not completed", f);
            end else begin
                e = exp0.pop_front();
                total++;
                if ({err0, dato0} !== e) begin bad++; $display("FAIL b2b_dato%0d got=%h exp=%h", f, {err0, dato0}, e); end
                if (f == 0) begin
                    cshi = 0; olow = 0;
                    while (cs0 && cshi < 50) begin
                        if (!ocup0) olow++;
                        cshi++;
                        @(negedge clk);
                    end
                    total += 2;
                    if (cshi !== 9) begin bad++; $display("FAIL b2b_cs_high got=%0d exp=9", cshi); end
                    if (olow !== 1) begin bad++; $display("FAIL b2b_ocupado_low got=%0d exp=1", olow); end
                end
            end
        end
        start0 = 1'b0;
        wait_idle0();
    endtask

    task automatic test_ignore_start();
        int j, base, nv;
        bit ok;
        logic [12:0] e;
        frames0.push_back({2'b11, 1'b0, 12'h3C7}); exp0.push_back({1'b0, 12'h3C7});
        frames0.push_back({2'b11, 1'b1, 12'hBAD});
        start0 = 1'b1; base = edges0; nv = nval0;
        @(negedge clk);
        start0 = 1'b0;
        repeat (39) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_valido0(j, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL ign_timeout no dato_valido");
        end else begin
            e = exp0.pop_front();
            total++;
            if ({err0, dato0} !== e) begin bad++; $display("FAIL ign_dato got=%h exp=%h", {err0, dato0}, e); end
        end
        repeat (200) @(negedge clk);
        total += 3;
        if (nval0 - nv !== 1)     begin bad++; $display("FAIL ign_valid_count got=%0d exp=1", nval0 - nv); end
        if (edges0 - base !== 15) begin bad++; $display("FAIL ign_edges got=%0d exp=15", edges0 - base); end
        if (ocup0 !== 1'b0)       begin bad++; $display("FAIL ign_idle got=%b exp=0", ocup0); end
        frames0.delete();
    endtask

    task automatic test_reset_midframe();
        int n, base, nv;
        frames0.push_back({2'b11, 1'b1, 12'h777});
        start0 = 1'b1; base = edges0; nv = nval0;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (edges0 - base < 7 && n < 200) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        @(negedge clk);
        total += 4;
        if (cs0 !== 1'b1)      begin bad++; $display("FAIL mid_cs got=%b exp=1", cs0); end
        if (clk_adc0 !== 1'b0) begin bad++; $display("FAIL mid_clk got=%b exp=0", clk_adc0); end
        if (ocup0 !== 1'b0)    begin bad++; $display("FAIL mid_ocupado got=%b exp=0", ocup0); end
        if (dato0 !== 12'h000) begin bad++; $display("FAIL mid_dato got=%h exp=000", dato0); end
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        total += 2;
        if (nval0 !== nv)         begin bad++; $display("FAIL mid_no_valid got=%0d exp=%0d", nval0, nv); end
        if (edges0 - base !== 7)  begin bad++; $display("FAIL mid_edges got=%0d exp=7", edges0 - base); end
        test_frame0(12'h6E2, 1'b0, "post_rst");
    endtask

    task automatic test_fast_corner();
        int j, base, cshi;
        bit ok;
        logic [12:0] e;
        frames1.push_back({2'b11, 1'b0, 12'h3C5}); exp1.push_back({1'b0, 12'h3C5});
        frames1.push_back({2'b11, 1'b1, 12'h5A3}); exp1.push_back({1'b1, 12'h5A3});
        frames1.push_back({2'b11, 1'b0, 12'h0F0}); exp1.push_back({1'b0, 12'h0F0});
        start1 = 1'b1; base = edges1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            wait_valido1(j, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL fast_timeout frame %0d", f);
            end else begin
                e = exp1.pop_front();
                total++;
                if ({err1, dato1} !== e) begin bad++; $display("FAIL fast_dato%0d got=%h exp=%h", f, {err1, dato1}, e); end
                if (f == 0) begin
                    total += 2;
                    if (j !== 30)             begin bad++; $display("FAIL fast_latency got=%0d exp=30", j); end
                    if (edges1 - base !== 15) begin bad++; $display("FAIL fast_edges got=%0d exp=15", edges1 - base); end
                end
                if (f == 2) start1 = 1'b0;
                cshi = 0;
                while (cs1 && cshi < 20 && f < 2) begin cshi++; @(negedge clk); end
                if (f < 2) begin
                    total++;
                    if (cshi !== 2) begin bad++; $display("FAIL fast_cs_high%0d got=%0d exp=2", f, cshi); end
                end
            end
        end
        start1 = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (nval1 !== 3) begin bad++; $display("FAIL fast_valid_count got=%0d exp=3", nval1); end
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame0(12'hA5C, 1'b0, "basic");
        test_frame0(12'h000, 1'b1, "null");
        test_back_to_back();
        test_ignore_start();
        test_reset_midframe();
        test_fast_corner();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
